moisture_actuator: RTL
======================

Name: moisture_actuator

Overview:
- Actuator-side controller for the moisture channel. It takes the same wet and ideal readings the moisture comparator uses and drives the humidifier and dehumidifier enables.
- Sequencing is handled by an FSM with hysteresis, minimum run time, post-run cooldown and a run-timeout fault.
- Sits between the moisture sensing path and the room's actuator relays.

Parameters:
- HYST, 2: dead-band in counts; no new action while |wet - ideal| <= HYST.
- MIN_ON, 8: minimum cycles an actuator stays on once started (>= 1).
- COOL, 4: cycles both actuators are held off after any run (>= 1).
- MAX_ON, 64: run-timeout in cycles; must be > MIN_ON.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- enable, input, 1: control enable; low forces actuation to stop.
- sample_valid, input, 1: wet/ideal are valid this cycle.
- wet, input, 6: measured moisture, unsigned 0..63.
- ideal, input, 6: target moisture, unsigned 0..63.
- fault_clr, input, 1: single-cycle pulse; clears FAULT.
- humid_on, output, 1: humidifier enable.
- dehumid_on, output, 1: dehumidifier enable.
- fault, output, 1: sticky run-timeout flag.
- state, output, 3: FSM state code: IDLE=0, HUMID=1, DEHUMID=2, COOL=3, FAULT=4.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, cycle counter=0.
  - humid_on=0, dehumid_on=0, fault=0, applied even mid-run.
- Arithmetic: compare in 7-bit unsigned; no wrap for any 0..63 input.
  - dry = (wet + HYST < ideal).
  - damp = (wet > ideal + HYST).
  - dry and damp are mutually exclusive.
- Outputs are decoded from the state register only: glitch-free, one cycle after the deciding edge.
  - humid_on = (state==HUMID).
  - dehumid_on = (state==DEHUMID).
  - fault = (state==FAULT).
  - humid_on and dehumid_on are never both 1.
- cnt counts cycles spent in the current state. It is 0 in the first cycle after entry and reloads to 0 on every state change.
- IDLE:
  - enable & sample_valid & dry -> HUMID.
  - enable & sample_valid & damp -> DEHUMID.
  - Otherwise stay.
- HUMID, priority order:
  1. enable=0 -> COOL; overrides MIN_ON.
  2. cnt >= MIN_ON-1 & sample_valid & wet >= ideal -> COOL.
  3. cnt == MAX_ON-1 -> FAULT.
  4. Otherwise stay; cnt++.
- DEHUMID: identical to HUMID, with exit condition wet <= ideal.
- Exit target is the setpoint, not the hysteresis edge. Once started, a run continues until the setpoint is reached.
- Inputs while running:
  - sample_valid=0 cycles never cause an exit.
  - Values on wet/ideal without sample_valid are ignored in every state.
- COOL:
  - Both actuators off; cnt++.
  - At cnt == COOL-1 -> IDLE.
  - Inputs are ignored, and a dry/damp sample during COOL starts nothing.
- FAULT:
  - Outputs off, fault=1.
  - Stays until a fault_clr pulse -> IDLE.
  - fault_clr in any other state is ignored.
- Minimum run: a run started at edge k lasts at least MIN_ON cycles of humid_on/dehumid_on high, unless enable drops.
- Timeout: if the exit condition never holds, FAULT is entered after exactly MAX_ON cycles in the run state. An exit condition in that same cycle wins over FAULT.
- Reachable states: state values 5..7 are unreachable and must recover to IDLE on the next edge.

Test Plan:
- Reset: assert rst mid-stream -> humid_on=0, dehumid_on=0, fault=0, state=0 without a clock edge.
- Humidify with minimum run:
  - Stimulus: ideal=27, wet=17, sample_valid=1 at edge k; wet=27 from edge k+2.
  - humid_on=1 from edge k through edge k+8, i.e. 8 cycles high.
  - state=3 for 4 cycles, then 0.
  - dehumid_on stays 0 throughout.
- Dehumidify: wet=27, ideal=17 valid -> dehumid_on=1 next cycle. Setting wet=17 after 10 cycles -> state=3 next edge.
- Dead-band and sample_valid gating:
  - wet=27, ideal=28 or wet=27, ideal=27 valid -> state stays 0, outputs 0.
  - wet=17, ideal=27 with sample_valid=0 -> no action.
- Timeout and fault handling:
  - wet=17, ideal=27 held -> fault=1 and humid_on=0 after 64 cycles; fault stays set with inputs toggling.
  - fault_clr pulse -> state=0.
- Edge cases:
  - enable dropped at cycle 3 of HUMID -> COOL next edge.
  - wet=0, ideal=63 -> HUMID.
  - wet=63, ideal=0 -> DEHUMID, with no overflow.

Source files
------------

// File: rtl/moisture_actuator_if.sv
// Moisture actuator control/status bundle: sensing inputs in, relay enables and status out.
interface moisture_actuator_if;
    logic       enable;
    logic       sample_valid;
    logic [5:0] wet;
    logic [5:0] ideal;
    logic       fault_clr;
    logic       humid_on;
    logic       dehumid_on;
    logic       fault;
    logic [2:0] state;

    // Controller side of the bundle
    modport master (
        output enable, sample_valid, wet, ideal, fault_clr,
        input  humid_on, dehumid_on, fault, state
    );

    // Actuator side of the bundle
    modport slave (
        input  enable, sample_valid, wet, ideal, fault_clr,
        output humid_on, dehumid_on, fault, state
    );
endinterface

// File: rtl/moisture_actuator.sv
// Moisture actuator sequencer: hysteresis start, minimum run, cooldown and run-timeout fault.
module moisture_actuator #(
    parameter int unsigned HYST   = 2,
    parameter int unsigned MIN_ON = 8,
    parameter int unsigned COOL   = 4,
    parameter int unsigned MAX_ON = 64
) (
    input  logic                clk,
    input  logic                rst,
    moisture_actuator_if.slave  io
);

    localparam int unsigned CNT_W = $clog2(MAX_ON);
    localparam int unsigned CMP_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HUMID   = 3'd1,
        ST_DEHUMID = 3'd2,
        ST_COOL    = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               humid_on_q, humid_on_d;
    logic               dehumid_on_q, dehumid_on_d;
    logic               fault_q, fault_d;

    logic [CMP_W-1:0]   wet_w, ideal_w, hyst_w;
    logic               dry_c, damp_c;
    logic               setpoint_hit_c;
    logic               min_done_c, timeout_c, cool_done_c;

    // Widened comparisons so wet/ideal +/- HYST never wrap
    always_comb begin
        wet_w   = CMP_W'(io.wet);
        ideal_w = CMP_W'(io.ideal);
        hyst_w  = CMP_W'(HYST);
        dry_c   = (wet_w + hyst_w) < ideal_w;
        damp_c  = wet_w > (ideal_w + hyst_w);
        setpoint_hit_c = (state_q == ST_HUMID) ? (wet_w >= ideal_w) : (wet_w <= ideal_w);
        min_done_c  = cnt_q >= CNT_W'(MIN_ON - 1);
        timeout_c   = cnt_q == CNT_W'(MAX_ON - 1);
        cool_done_c = cnt_q == CNT_W'(COOL - 1);
    end

    // Next-state, dwell counter and decoded output values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (io.enable && io.sample_valid && dry_c) begin
                    state_d = ST_HUMID;
                end else if (io.enable && io.sample_valid && damp_c) begin
                    state_d = ST_DEHUMID;
                end
            end
            ST_HUMID, ST_DEHUMID: begin
                // Setpoint exit outranks timeout when both land on the same cycle
                if (!io.enable) begin
                    state_d = ST_COOL;
                end else if (min_done_c && io.sample_valid && setpoint_hit_c) begin
                    state_d = ST_COOL;
                end else if (timeout_c) begin
                    state_d = ST_FAULT;
                end
            end
            ST_COOL: begin
                if (cool_done_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                cnt_d = '0;
                if (io.fault_clr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
        humid_on_d   = (state_d == ST_HUMID);
        dehumid_on_d = (state_d == ST_DEHUMID);
        fault_d      = (state_d == ST_FAULT);
    end

    // State, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            humid_on_q   <= 1'b0;
            dehumid_on_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            humid_on_q   <= humid_on_d;
            dehumid_on_q <= dehumid_on_d;
            fault_q      <= fault_d;
        end
    end

    assign io.humid_on   = humid_on_q;
    assign io.dehumid_on = dehumid_on_q;
    assign io.fault      = fault_q;
    assign io.state      = state_q;

endmodule
